// File: rtl/accel_spi_responder_if.sv
// SPI pin bundle between the accel SPI master and the register-bank responder.
// The master drives clock, select and MOSI; the slave returns MISO and its drive enable.
interface accel_spi_responder_if;
  logic spi_sclk;
  logic spi_ss_n;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (
    output spi_sclk,
    output spi_ss_n,
    output spi_mosi,
    input  spi_miso,
    input  spi_miso_oe
  );

  modport slave (
    input  spi_sclk,
    input  spi_ss_n,
    input  spi_mosi,
    output spi_miso,
    output spi_miso_oe
  );
endinterface

// File: rtl/accel_spi_responder.sv
// SPI mode-3 slave emulating a 64x8 accelerometer register bank, with X/Y/Z samples
// injected from the fabric and held back while a frame is in flight so reads stay coherent.
module accel_spi_responder #(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  accel_spi_responder_if.slave spi,
  input  logic                 sample_valid,
  input  logic [15:0]          sample_x,
  input  logic [15:0]          sample_y,
  input  logic [15:0]          sample_z,
  output logic                 wr_strobe,
  output logic [5:0]           wr_addr,
  output logic [7:0]           wr_data,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  function automatic logic is_writable(input logic [5:0] a);
    return (a != 6'h00) && ((a < 6'h32) || (a > 6'h37));
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] ss_n_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic                   sclk_d_r;
  logic                   ss_n_d_r;
  logic                   sclk_s;
  logic                   ss_n_s;
  logic                   mosi_s;
  logic                   sclk_rise_s;
  logic                   sclk_fall_s;
  logic                   ss_fall_s;
  logic                   ss_rise_s;
  logic                   active_s;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [2:0]             bit_cnt_r;
  logic [7:0]             shift_in_r;
  logic [7:0]             shift_out_r;
  logic [5:0]             addr_r;
  logic [5:0]             addr_nxt_s;
  logic                   rw_r;
  logic                   rw_nxt_s;
  logic                   mb_r;
  logic                   mb_nxt_s;
  logic [7:0]             byte_s;
  logic                   byte_done_s;
  logic                   load_out_s;
  logic [7:0]             load_val_s;
  logic                   wr_en_s;

  logic [63:0][7:0]       regs_r;
  logic [47:0]            shadow_r;
  logic                   pending_r;

  logic                   miso_r;
  logic                   busy_r;
  logic                   wr_strobe_r;
  logic [5:0]             wr_addr_r;
  logic [7:0]             wr_data_r;

  // Input synchronizers and one-cycle delayed copies for edge detection
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sclk_sync_r <= {SYNC_STAGES{1'b1}};
      ss_n_sync_r <= {SYNC_STAGES{1'b1}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      sclk_d_r    <= 1'b1;
      ss_n_d_r    <= 1'b1;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi.spi_sclk};
      ss_n_sync_r <= {ss_n_sync_r[SYNC_STAGES-2:0], spi.spi_ss_n};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi.spi_mosi};
      sclk_d_r    <= sclk_s;
      ss_n_d_r    <= ss_n_s;
    end
  end

  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign ss_n_s      = ss_n_sync_r[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_d_r;
  assign sclk_fall_s = ~sclk_s & sclk_d_r;
  assign ss_fall_s   = ~ss_n_s & ss_n_d_r;
  assign ss_rise_s   = ss_n_s & ~ss_n_d_r;
  assign active_s    = (state_r != ST_IDLE);
  assign byte_s      = {shift_in_r[6:0], mosi_s};
  assign byte_done_s = sclk_rise_s & active_s & (bit_cnt_r == 3'd7);

  // Frame FSM: command decode, address stepping, MISO preload and write enable
  always_comb begin
    state_nxt_s = state_r;
    addr_nxt_s  = addr_r;
    rw_nxt_s    = rw_r;
    mb_nxt_s    = mb_r;
    load_out_s  = 1'b0;
    load_val_s  = 8'h00;
    wr_en_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ss_fall_s) begin
          state_nxt_s = ST_CMD;
          load_out_s  = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (ss_rise_s) begin
          state_nxt_s = ST_IDLE;
        end else if (byte_done_s) begin
          state_nxt_s = ST_DATA;
          rw_nxt_s    = byte_s[7];
          mb_nxt_s    = byte_s[6];
          addr_nxt_s  = byte_s[5:0];
          load_out_s  = 1'b1;
          load_val_s  = regs_r[byte_s[5:0]];
        end else begin
          state_nxt_s = ST_CMD;
        end
      end
      ST_DATA: begin
        if (ss_rise_s) begin
          state_nxt_s = ST_IDLE;
        end else if (byte_done_s) begin
          wr_en_s     = ~rw_r & is_writable(addr_r);
          addr_nxt_s  = mb_r ? (addr_r + 6'd1) : addr_r;
          load_out_s  = 1'b1;
          load_val_s  = regs_r[addr_nxt_s];
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and decoded command fields
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      addr_r  <= 6'h00;
      rw_r    <= 1'b0;
      mb_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      addr_r  <= addr_nxt_s;
      rw_r    <= rw_nxt_s;
      mb_r    <= mb_nxt_s;
    end
  end

  // Bit counter and shift registers; a partial byte dies with the frame
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bit_cnt_r   <= 3'd0;
      shift_in_r  <= 8'h00;
      shift_out_r <= 8'h00;
    end else begin
      if (!active_s || ss_rise_s) begin
        bit_cnt_r <= 3'd0;
      end else if (sclk_rise_s) begin
        bit_cnt_r  <= bit_cnt_r + 3'd1;
        shift_in_r <= byte_s;
      end
      if (load_out_s) begin
        shift_out_r <= load_val_s;
      end else if (sclk_fall_s && active_s) begin
        shift_out_r <= {shift_out_r[6:0], 1'b0};
      end
    end
  end

  // Register bank: SPI writes plus sample updates deferred while the bus is busy
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      regs_r    <= {{63{8'h00}}, DEVID};
      shadow_r  <= 48'h0;
      pending_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        regs_r[addr_r] <= byte_s;
      end
      if (sample_valid && busy_r) begin
        shadow_r  <= {sample_z, sample_y, sample_x};
        pending_r <= 1'b1;
      end else if (sample_valid) begin
        regs_r[6'h37:6'h32] <= {sample_z, sample_y, sample_x};
        pending_r           <= 1'b0;
      end else if (pending_r && !busy_r) begin
        regs_r[6'h37:6'h32] <= shadow_r;
        pending_r           <= 1'b0;
      end
    end
  end

  // Registered pin and host-side outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      miso_r      <= 1'b0;
      busy_r      <= 1'b0;
      wr_strobe_r <= 1'b0;
      wr_addr_r   <= 6'h00;
      wr_data_r   <= 8'h00;
    end else begin
      busy_r      <= ~ss_n_s;
      wr_strobe_r <= wr_en_s;
      if (wr_en_s) begin
        wr_addr_r <= addr_r;
        wr_data_r <= byte_s;
      end
      if (ss_n_s) begin
        miso_r <= 1'b0;
      end else if (sclk_fall_s && active_s) begin
        miso_r <= shift_out_r[7];
      end
    end
  end

  assign spi.spi_miso    = miso_r;
  assign spi.spi_miso_oe = busy_r;
  assign busy            = busy_r;
  assign wr_strobe       = wr_strobe_r;
  assign wr_addr         = wr_addr_r;
  assign wr_data         = wr_data_r;

endmodule

// File: tb/tb_accel_spi_responder.sv
// Scoreboard bench for accel_spi_responder: expected MISO bytes and write strobes are
// queued as stimulus is driven, then popped and compared against what the DUT produced.
module tb_accel_spi_responder;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_valid;
  logic [15:0] sample_x;
  logic [15:0] sample_y;
  logic [15:0] sample_z;
  logic        wr_strobe;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;

  accel_spi_responder_if spi_bus();

  accel_spi_responder #(.DEVID(8'hE5), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .spi          (spi_bus),
    .sample_valid (sample_valid),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .sample_z     (sample_z),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  exp_q[$];
  logic [13:0] exp_strobe_q[$];
  logic [13:0] strobe_q[$];
  logic [7:0]  tx_buf [0:15];
  logic [7:0]  rx_buf [0:15];
  logic [47:0] inj_tab [0:1];
  logic        oe_low_seen;
  logic        busy_low_seen;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) strobe_q.push_back({wr_addr, wr_data});
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_sample(input logic [47:0] v);
    sample_x     = v[15:0];
    sample_y     = v[31:16];
    sample_z     = v[47:32];
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Mode-3 frame: SCLK half period 5 clk; the last byte may be cut short to last_bits
  task automatic spi_frame(input int nbytes, input int last_bits, input int inj_a, input int inj_b);
    int nbits;
    oe_low_seen   = 1'b0;
    busy_low_seen = 1'b0;
    spi_bus.spi_ss_n = 1'b0;
    wait_clk(6);
    for (int b = 0; b < nbytes; b++) begin
      if (b == inj_a) pulse_sample(inj_tab[0]);
      if (b == inj_b) pulse_sample(inj_tab[1]);
      nbits = (b == nbytes - 1) ? last_bits : 8;
      rx_buf[b] = 8'h00;
      for (int i = 0; i < nbits; i++) begin
        spi_bus.spi_sclk = 1'b0;
        spi_bus.spi_mosi = tx_buf[b][7-i];
        wait_clk(5);
        if (spi_bus.spi_miso_oe !== 1'b1) oe_low_seen = 1'b1;
        if (busy !== 1'b1) busy_low_seen = 1'b1;
        rx_buf[b][7-i] = spi_bus.spi_miso;
        spi_bus.spi_sclk = 1'b1;
        wait_clk(5);
      end
    end
    spi_bus.spi_ss_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wait_clk(4);
    n_tests++; if (spi_bus.spi_miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b want 0", spi_bus.spi_miso); end
    n_tests++; if (spi_bus.spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b want 0", spi_bus.spi_miso_oe); end
    n_tests++; if (wr_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b want 0", wr_strobe); end
    n_tests++; if (wr_addr !== 6'h00) begin n_fail++; $display("FAIL reset_wr_addr: got %h want 00", wr_addr); end
    n_tests++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset_n = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_devid();
    logic [7:0] exp;
    tx_buf[0] = 8'h80; tx_buf[1] = 8'h00;
    exp_q.push_back(8'h00); exp_q.push_back(8'hE5);
    spi_frame(2, 8, -1, -1);
    for (int b = 0; b < 2; b++) begin
      exp = exp_q.pop_front();
      n_tests++; if (rx_buf[b] !== exp) begin n_fail++; $display("FAIL devid_byte%0d: got %h want %h", b, rx_buf[b], exp); end
    end
    n_tests++; if (oe_low_seen !== 1'b0) begin n_fail++; $display("FAIL devid_oe_in_frame: got low want high"); end
    n_tests++; if (busy_low_seen !== 1'b0) begin n_fail++; $display("FAIL devid_busy_in_frame: got low want high"); end
    n_tests++; if (spi_bus.spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL devid_oe_after: got %b want 0", spi_bus.spi_miso_oe); end
    n_tests++; if (spi_bus.spi_miso !== 1'b0) begin n_fail++; $display("FAIL devid_miso_after: got %b want 0", spi_bus.spi_miso); end
    n_tests++; if (strobe_q.size() != 0) begin n_fail++; $display("FAIL devid_no_strobe: got %0d strobes want 0", strobe_q.size()); end
    strobe_q.delete();
  endtask

  task automatic test_samples();
    logic [7:0] exp;
    pulse_sample({16'h8001, 16'hFFFE, 16'h1234});
    wait_clk(2);
    tx_buf[0] = 8'hF2;
    for (int b = 1; b < 7; b++) tx_buf[b] = 8'h00;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    exp_q.push_back(8'hFE); exp_q.push_back(8'hFF);
    exp_q.push_back(8'h01); exp_q.push_back(8'h80);
    spi_frame(7, 8, -1, -1);
    for (int b = 0; b < 7; b++) begin
      exp = exp_q.pop_front();
      n_tests++; if (rx_buf[b] !== exp) begin n_fail++; $display("FAIL sample_byte%0d: got %h want %h", b, rx_buf[b], exp); end
    end
  endtask

  task automatic test_write();
    logic [7:0]  exp;
    logic [13:0] exp_s;
    tx_buf[0] = 8'h2D; tx_buf[1] = 8'h08;
    exp_strobe_q.push_back({6'h2D, 8'h08});
    spi_frame(2, 8, -1, -1);
    n_tests++; if (strobe_q.size() != exp_strobe_q.size()) begin n_fail++; $display("FAIL write_strobe_count: got %0d want %0d", strobe_q.size(), exp_strobe_q.size()); end
    while (exp_strobe_q.size() > 0 && strobe_q.size() > 0) begin
      exp_s = exp_strobe_q.pop_front();
      n_tests++; if (strobe_q[0] !== exp_s) begin n_fail++; $display("FAIL write_strobe: got %h want %h", strobe_q[0], exp_s); end
      void'(strobe_q.pop_front());
    end
    exp_strobe_q.delete(); strobe_q.delete();
    tx_buf[0] = 8'hAD; tx_buf[1] = 8'h00;
    exp_q.push_back(8'h00); exp_q.push_back(8'h08);
    spi_frame(2, 8, -1, -1);
    for (int b = 0; b < 2; b++) begin
      exp = exp_q.pop_front();
      n_tests++; if (rx_buf[b] !== exp) begin n_fail++; $display("FAIL write_readback%0d: got %h want %h", b, rx_buf[b], exp); end
    end
    n_tests++; if (wr_addr !== 6'h2D || wr_data !== 8'h08) begin n_fail++; $display("FAIL write_hold: got %h/%h want 2d/08", wr_addr, wr_data); end
  endtask

  task automatic test_mb_write();
    logic [7:0]  exp;
    logic [13:0] exp_s;
    tx_buf[0] = 8'h7F; tx_buf[1] = 8'hAA; tx_buf[2] = 8'hBB;
    exp_strobe_q.push_back({6'h3F, 8'hAA});
    spi_frame(3, 8, -1, -1);
    n_tests++; if (strobe_q.size() != exp_strobe_q.size()) begin n_fail++; $display("FAIL mbw_strobe_count: got %0d want %0d", strobe_q.size(), exp_strobe_q.size()); end
    while (exp_strobe_q.size() > 0 && strobe_q.size() > 0) begin
      exp_s = exp_strobe_q.pop_front();
      n_tests++; if (strobe_q[0] !== exp_s) begin n_fail++; $display("FAIL mbw_strobe: got %h want %h", strobe_q[0], exp_s); end
      void'(strobe_q.pop_front());
    end
    exp_strobe_q.delete(); strobe_q.delete();
    // Read back 0x3F, 0x00 and 0x01 as three single-byte reads
    tx_buf[1] = 8'h00;
    for (int k = 0; k < 3; k++) begin
      tx_buf[0] = (k == 0) ? 8'hBF : ((k == 1) ? 8'h80 : 8'h81);
      exp_q.push_back(8'h00);
      exp_q.push_back((k == 0) ? 8'hAA : ((k == 1) ? 8'hE5 : 8'h00));
      spi_frame(2, 8, -1, -1);
      for (int b = 0; b < 2; b++) begin
        exp = exp_q.pop_front();
        n_tests++; if (rx_buf[b] !== exp) begin n_fail++; $display("FAIL mbw_read%0d_byte%0d: got %h want %h", k, b, rx_buf[b], exp); end
      end
    end
    n_tests++; if (wr_addr !== 6'h3F || wr_data !== 8'hAA) begin n_fail++; $display("FAIL mbw_hold: got %h/%h want 3f/aa", wr_addr, wr_data); end
  endtask

  task automatic test_coherency();
    logic [7:0] exp;
    inj_tab[0] = {16'h2222, 16'h3333, 16'h4444};
    inj_tab[1] = {16'h7FFF, 16'h0F0F, 16'hA5C3};
    tx_buf[0] = 8'hF2;
    for (int b = 1; b < 7; b++) tx_buf[b] = 8'h00;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    exp_q.push_back(8'hFE); exp_q.push_back(8'hFF);
    exp_q.push_back(8'h01); exp_q.push_back(8'h80);
    spi_frame(7, 8, 2, 4);
    for (int b = 0; b < 7; b++) begin
      exp = exp_q.pop_front();
      n_tests++; if (rx_buf[b] !== exp) begin n_fail++; $display("FAIL coh_old_byte%0d: got %h want %h", b, rx_buf[b], exp); end
    end
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hC3); exp_q.push_back(8'hA5);
    exp_q.push_back(8'h0F); exp_q.push_back(8'h0F);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h7F);
    spi_frame(7, 8, -1, -1);
    for (int b = 0; b < 7; b++) begin
      exp = exp_q.pop_front();
      n_tests++; if (rx_buf[b] !== exp) begin n_fail++; $display("FAIL coh_new_byte%0d: got %h want %h", b, rx_buf[b], exp); end
    end
  endtask

  task automatic test_abort();
    logic [7:0]  exp;
    logic [13:0] exp_s;
    tx_buf[0] = 8'h2E; tx_buf[1] = 8'h5A;
    spi_frame(2, 5, -1, -1);
    n_tests++; if (strobe_q.size() != 0) begin n_fail++; $display("FAIL abort_no_strobe: got %0d strobes want 0", strobe_q.size()); end
    strobe_q.delete();
    tx_buf[0] = 8'hAE; tx_buf[1] = 8'h00;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    spi_frame(2, 8, -1, -1);
    for (int b = 0; b < 2; b++) begin
      exp = exp_q.pop_front();
      n_tests++; if (rx_buf[b] !== exp) begin n_fail++; $display("FAIL abort_unchanged%0d: got %h want %h", b, rx_buf[b], exp); end
    end
    // Back-to-back: full write then readback after the aborted frame
    tx_buf[0] = 8'h2E; tx_buf[1] = 8'h5A;
    exp_strobe_q.push_back({6'h2E, 8'h5A});
    spi_frame(2, 8, -1, -1);
    n_tests++; if (strobe_q.size() != exp_strobe_q.size()) begin n_fail++; $display("FAIL b2b_strobe_count: got %0d want %0d", strobe_q.size(), exp_strobe_q.size()); end
    while (exp_strobe_q.size() > 0 && strobe_q.size() > 0) begin
      exp_s = exp_strobe_q.pop_front();
      n_tests++; if (strobe_q[0] !== exp_s) begin n_fail++; $display("FAIL b2b_strobe: got %h want %h", strobe_q[0], exp_s); end
      void'(strobe_q.pop_front());
    end
    exp_strobe_q.delete(); strobe_q.delete();
    tx_buf[0] = 8'hAE; tx_buf[1] = 8'h00;
    exp_q.push_back(8'h00); exp_q.push_back(8'h5A);
    spi_frame(2, 8, -1, -1);
    for (int b = 0; b < 2; b++) begin
      exp = exp_q.pop_front();
      n_tests++; if (rx_buf[b] !== exp) begin n_fail++; $display("FAIL b2b_readback%0d: got %h want %h", b, rx_buf[b], exp); end
    end
  endtask

  initial begin
    reset_n          = 1'b0;
    sample_valid     = 1'b0;
    sample_x         = 16'h0000;
    sample_y         = 16'h0000;
    sample_z         = 16'h0000;
    spi_bus.spi_sclk = 1'b1;
    spi_bus.spi_ss_n = 1'b1;
    spi_bus.spi_mosi = 1'b0;
    wait_clk(2);
    test_reset();
    test_devid();
    test_samples();
    test_write();
    test_mb_write();
    test_coherency();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
